reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Per-register destination scoreboard for the issue stage. It records every outstanding register write issued to a multi-cycle unit and counts down until that result is written back. It compares the decode-stage instruction's source and destination registers against the outstanding writes and drives the `rD_conflict` input of the hazard detection unit. It is directly upstream of the HDU and consumes the HDU's `issue_ok` to create each reservation.

## Interface
- `NREG`, 32: number of architectural registers; register 0 is hardwired zero.
- `AW`, 5: register address width, log2(NREG).
- `DW`, 3: width of `op_delay`, matching the HDU reservation window of 0..7.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low (0 = reset).
- `issue_ok`  in  1: HDU grant; the decode-stage instruction issues at this edge.
- `op_delay`  in  DW: result latency of the decode-stage instruction, in cycles.
- `rd`  in  AW: destination register of the decode-stage instruction.
- `rd_we`  in  1: the instruction writes `rd`.
- `ra`, `rb`  in  AW each: source registers.
- `ra_use`, `rb_use`  in  1 each: the corresponding source is read.
- `flush`  in  1: pipeline flush; drop all reservations.
- `rD_conflict`  out  1: hazard on the current decode instruction (combinational).
- `pending`  out  NREG: registered pending bit per register.
- `busy`  out  1: OR of `pending`.

## Operation
- Each entry r holds `pend[r]` (1 bit) and `cnt[r]` (DW bits). All entries reset to 0.
- **Reserve:** when `issue_ok && rd_we && rd != 0 && op_delay != 0`, set `pend[rd] = 1` and `cnt[rd] = op_delay`.
  - No reservation is made when `op_delay == 0`; such a result is usable next cycle.
- **Countdown:** each edge, every entry with `pend = 1` that is not being reserved decrements `cnt`.
  - An entry with `cnt == 1` clears `pend` and `cnt` to 0 at that edge.
- **Conflict:** `rD_conflict = (ra_use && ra != 0 && pend[ra]) || (rb_use && rb != 0 && pend[rb]) || (rd_we && rd != 0 && pend[rd])`.
  - This covers RAW on either source and WAW on the destination.
  - Register 0 never conflicts and is never reserved.
  - `rD_conflict` depends only on state and decode fields, never on `issue_ok`, so there is no combinational loop through the HDU.
- **Same-register events in one cycle:** if a reservation targets an entry that is clearing at the same edge, the reservation wins and the entry ends with `pend = 1`, `cnt = op_delay`.
  - A reservation onto an already-pending entry (illegal, since the HDU stalls it) overwrites `cnt` with the new `op_delay`.
- **Flush:** clears every entry at the edge and overrides a simultaneous reservation.
- **Reset priority:** reset overrides flush and reserve. Reset mid-countdown clears every entry.
- `issue_ok` asserted while `rd_we = 0` changes no state.

## Timing
- Reservation at edge k with delay d: `pend` is 1 in cycles k+1 .. k+d and 0 from cycle k+d+1 onward.
  - A dependent instruction in decode therefore sees `rD_conflict = 1` for exactly d cycles.
- `pending` and `busy` are registered and reflect state one cycle after the causing edge.
- `rD_conflict` is combinational, valid in the same cycle as the decode fields.
- Reset values: `pending = 0`, `busy = 0`. `rD_conflict = 0` whenever the state is clear.
- Counter arithmetic is unsigned DW-bit. It never wraps, because the decrement applies only while `cnt >= 1`.

## Structure
- Shared package `cmp_pkg`: `NREG`, `AW`, `DW` constants and a register-index typedef.
  - The HDU and this block both import `DW` from the package, so latency widths agree.
- One natural sub-module, `sb_entry`: a single pending bit plus down-counter.
  - Inputs: `set`, `load_val`, `clr`.
  - Outputs: `pend`.
  - The top instantiates NREG-1 copies (registers 1..NREG-1) and contains the decode, the conflict mux and the OR-reduce.

## Test plan
- **Reset:** hold `reset = 0` for 2 cycles with random inputs → `pending = 0`, `busy = 0`, `rD_conflict = 0`.
- **RAW countdown:** issue `rd = 5`, `op_delay = 3`, then hold `ra = 5`, `ra_use = 1` → `rD_conflict = 1` for exactly 3 cycles, 0 on the 4th; `pending[5]` falls on the same cycle.
- **Zero register and zero delay:** issue `rd = 0`, `op_delay = 4` and `rd = 7`, `op_delay = 0` → no `pending` bit set; `ra = 0` / `ra = 7` never conflict.
- **Reservation wins over clear:** reserve `rd = 9`, `op_delay = 2`; on the cycle its `cnt = 1`, reserve `rd = 9`, `op_delay = 5` → `pending[9]` stays 1 for 5 more cycles.
- **WAW:** `rd = 12` pending; decode `rd = 12`, `rd_we = 1`, no sources used → `rD_conflict = 1`; with `rd_we = 0` → 0.
- **Flush and reset mid-operation:** with regs 3 (`cnt = 6`) and 4 (`cnt = 2`) pending:
  - Assert `flush` together with a reserve of reg 8 → `pending = 0`, `busy = 0` next cycle.
  - Repeat using `reset = 0` instead of `flush` → same result.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants for the issue-stage register scoreboard and the HDU.
package cmp_pkg;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 3;

   typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard entry: a pending bit plus a down-counter of remaining result latency.
module sb_entry
   import cmp_pkg::*;
#(
   parameter int W = DW
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         set,
   input  logic [W-1:0] load_val,
   input  logic         clr,
   output logic         pend
);

   logic         pend_d, pend_q;
   logic [W-1:0] cnt_d,  cnt_q;

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch is inferred.
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (clr) begin
         pend_d = 1'b0;
         cnt_d  = '0;
      end else if (set) begin
         pend_d = 1'b1;
         cnt_d  = load_val;
      end else if (pend_q) begin
         // The last outstanding cycle retires the entry, so the counter never wraps.
         if (cnt_q <= W'(1)) begin
            pend_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d  = cnt_q - W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the edge; non-blocking so both flops see pre-edge values.
      if (!reset) begin
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Destination-register scoreboard: reserves multi-cycle results and flags RAW/WAW hazards.
module reg_scoreboard
   import cmp_pkg::*;
#(
   parameter int NREG = cmp_pkg::NREG,
   parameter int AW   = cmp_pkg::AW,
   parameter int DW   = cmp_pkg::DW
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_ok,
   input  logic [DW-1:0]   op_delay,
   input  logic [AW-1:0]   rd,
   input  logic            rd_we,
   input  logic [AW-1:0]   ra,
   input  logic [AW-1:0]   rb,
   input  logic            ra_use,
   input  logic            rb_use,
   input  logic            flush,
   output logic            rD_conflict,
   output logic [NREG-1:0] pending,
   output logic            busy
);

   logic reserve;

   // Zero-latency results are forwarded next cycle, so they never hold an entry.
   assign reserve = issue_ok && rd_we && (rd != '0) && (op_delay != '0);

   assign pending[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      sb_entry #(.W(DW)) u_entry (
         .clk      (clk),
         .reset    (reset),
         .set      (reserve && (rd == AW'(r))),
         .load_val (op_delay),
         .clr      (flush),
         .pend     (pending[r])
      );
   end

   // Independent of issue_ok so the HDU sees no combinational loop back through this block.
   assign rD_conflict = (ra_use && (ra != '0) && pending[ra])
                     || (rb_use && (rb != '0) && pending[rb])
                     || (rd_we  && (rd != '0) && pending[rd]);

   assign busy = |pending;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vectors, corner sequences, random vs model.
module tb_reg_scoreboard;
   import cmp_pkg::*;

   logic            clk = 1'b0;
   logic            reset, issue_ok, rd_we, ra_use, rb_use, flush;
   logic [DW-1:0]   op_delay;
   reg_idx_t        rd, ra, rb;
   logic            rD_conflict;
   logic [NREG-1:0] pending;
   logic            busy;

   int total = 0;
   int bad   = 0;

   // Model: a register is pending while the current cycle index is below its release cycle.
   longint unsigned now = 0;
   longint unsigned ready_at [NREG];

   typedef struct {
      logic            issue;
      logic [DW-1:0]   dly;
      int              rd;
      logic            we;
      int              ra;
      logic            rau;
      int              rb;
      logic            rbu;
      logic            fl;
      logic            exp_conf;
      logic [NREG-1:0] exp_pend;
   } vec_t;

   vec_t tbl [14];

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .issue_ok    (issue_ok),
      .op_delay    (op_delay),
      .rd          (rd),
      .rd_we       (rd_we),
      .ra          (ra),
      .rb          (rb),
      .ra_use      (ra_use),
      .rb_use      (rb_use),
      .flush       (flush),
      .rD_conflict (rD_conflict),
      .pending     (pending),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [NREG-1:0] model_pending();
      logic [NREG-1:0] v;
      v = '0;
      for (int r = 1; r < NREG; r++) v[r] = (now < ready_at[r]);
      return v;
   endfunction

   function automatic logic model_conf();
      logic [NREG-1:0] p;
      p = model_pending();
      return (ra_use && ra != 0 && p[ra]) || (rb_use && rb != 0 && p[rb])
          || (rd_we && rd != 0 && p[rd]);
   endfunction

   task automatic clock_edge();
      if (!reset || flush) begin
         for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      end else if (issue_ok && rd_we && rd != 0 && op_delay != 0) begin
         ready_at[rd] = now + 1 + longint'(op_delay);
      end
      @(posedge clk);
      #1;
      now++;
   endtask

   task automatic idle();
      reset = 1'b1; issue_ok = 1'b0; rd_we = 1'b0; ra_use = 1'b0; rb_use = 1'b0;
      flush = 1'b0; op_delay = '0; rd = '0; ra = '0; rb = '0;
   endtask

   task automatic reserve(input int r, input int d);
      idle();
      issue_ok = 1'b1; rd_we = 1'b1; rd = reg_idx_t'(r); op_delay = DW'(d);
   endtask

   task automatic randomize_inputs();
      issue_ok = 1'($urandom_range(0, 1));
      rd_we    = 1'($urandom_range(0, 1));
      ra_use   = 1'($urandom_range(0, 1));
      rb_use   = 1'($urandom_range(0, 1));
      op_delay = DW'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom) : reg_idx_t'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom) : reg_idx_t'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom) : reg_idx_t'($urandom_range(0, 7));
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;

      //                issue dly rd we  ra rau rb rbu fl conf pend
      tbl[0]  = '{1'b1, 3'd3, 5,  1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd1 << 5};
      tbl[1]  = '{1'b0, 3'd0, 0,  1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'd1 << 5};
      tbl[2]  = '{1'b0, 3'd0, 0,  1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 32'd1 << 5};
      tbl[3]  = '{1'b0, 3'd0, 0,  1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'd0};
      tbl[4]  = '{1'b0, 3'd0, 0,  1'b0, 5, 1'b1, 5, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[5]  = '{1'b1, 3'd4, 0,  1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[6]  = '{1'b1, 3'd0, 7,  1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[7]  = '{1'b0, 3'd0, 0,  1'b0, 7, 1'b1, 0, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[8]  = '{1'b1, 3'd2, 12, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd1 << 12};
      tbl[9]  = '{1'b0, 3'd0, 12, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'd1 << 12};
      tbl[10] = '{1'b0, 3'd0, 12, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[11] = '{1'b1, 3'd5, 3,  1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[12] = '{1'b1, 3'd3, 6,  1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd1 << 6};
      tbl[13] = '{1'b1, 3'd2, 10, 1'b1, 6, 1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0};

      // Reset held two cycles under random decode traffic.
      randomize_inputs();
      flush = 1'($urandom_range(0, 1));
      reset = 1'b0;
      #2;
      clock_edge();
      randomize_inputs();
      clock_edge();
      check("reset pending", 64'(pending), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset conflict", 64'(rD_conflict), 64'd0);

      // Directed vectors: one row per cycle, conflict before the edge, state after it.
      for (int i = 0; i < 14; i++) begin
         idle();
         issue_ok = tbl[i].issue; op_delay = tbl[i].dly; rd = reg_idx_t'(tbl[i].rd);
         rd_we = tbl[i].we; ra = reg_idx_t'(tbl[i].ra); ra_use = tbl[i].rau;
         rb = reg_idx_t'(tbl[i].rb); rb_use = tbl[i].rbu; flush = tbl[i].fl;
         #1;
         check($sformatf("vec%0d conflict", i), 64'(rD_conflict), 64'(tbl[i].exp_conf));
         clock_edge();
         check($sformatf("vec%0d pending", i), 64'(pending), 64'(tbl[i].exp_pend));
         check($sformatf("vec%0d busy", i), 64'(busy), 64'(|tbl[i].exp_pend));
      end

      // Reservation on the entry's last cycle restarts it with the new latency.
      reserve(9, 2);
      clock_edge();
      idle();
      clock_edge();
      reserve(9, 5);
      #1;
      check("rewin waw conflict", 64'(rD_conflict), 64'd1);
      clock_edge();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rewin pend9 c%0d", i), 64'(pending[9]), 64'd1);
         idle();
         clock_edge();
      end
      check("rewin pend9 end", 64'(pending), 64'd0);

      // Flush, then reset, with two entries mid-countdown and a competing reservation.
      for (int pass = 0; pass < 2; pass++) begin
         reserve(3, 7);
         clock_edge();
         reserve(4, 2);
         clock_edge();
         check($sformatf("kill%0d setup", pass), 64'(pending), 64'h18);
         reserve(8, 3);
         if (pass == 0) flush = 1'b1;
         else           reset = 1'b0;
         clock_edge();
         idle();
         #1;
         check($sformatf("kill%0d pending", pass), 64'(pending), 64'd0);
         check($sformatf("kill%0d busy", pass), 64'(busy), 64'd0);
      end

      // Random traffic against the release-cycle model.
      for (int c = 0; c < 400; c++) begin
         randomize_inputs();
         flush = ($urandom_range(0, 29) == 0);
         reset = ($urandom_range(0, 49) != 0);
         #1;
         check($sformatf("rand%0d conflict", c), 64'(rD_conflict), 64'(model_conf()));
         clock_edge();
         check($sformatf("rand%0d pending", c), 64'(pending), 64'(model_pending()));
         check($sformatf("rand%0d busy", c), 64'(busy), 64'(|model_pending()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
